// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states,
// frame constants and the sample-tick divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK_WAIT
  } rx_state_e;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic IDLE_LEVEL      = 1'b1;

  // Clocks per sample tick, rounded to the nearest integer.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Sample-tick divider: emits a one-clock tick every DIV clocks. The
// synchronous clear holds the count at zero so the tick phase can be
// realigned to an external event such as a detected start edge.
module uart_os_tick #(
  parameter int DIV = 78
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: cleared on request, otherwise wraps after DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// Oversampling 8N1 UART receiver. The line is synchronized, sampled
// OVERSAMPLE times per bit and each bit is resolved by a 3-vote majority
// around mid-bit. Good bytes land in a valid/ready holding register;
// framing errors, breaks and overruns are reported as one-clock pulses.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_in,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_break,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);

  // Residual rate error check: |CLK - DIV*rate| / (DIV*rate) must stay below 2%.
  localparam longint TICK_RATE = longint'(BAUD) * longint'(OVERSAMPLE);
  localparam longint ACTUAL    = longint'(DIV) * TICK_RATE;
  localparam longint RATE_ERR  = (longint'(CLK_FREQ) > ACTUAL) ?
                                 (longint'(CLK_FREQ) - ACTUAL) :
                                 (ACTUAL - longint'(CLK_FREQ));

  if (OVERSAMPLE < 8 || OVERSAMPLE > 16) begin : g_bad_os
    $error("uart_rx_os16: OVERSAMPLE must be within 8..16");
  end
  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_os16: clock too slow for requested baud rate");
  end
  if (RATE_ERR * 50 >= ACTUAL) begin : g_bad_rate
    $error("uart_rx_os16: baud rate error of integer divider is 2%% or more");
  end

  // Vote positions around mid-bit and the last sample index of a bit.
  localparam int       MID      = OVERSAMPLE / 2;
  localparam logic [3:0] VOTE_A  = 4'(MID - 1);
  localparam logic [3:0] VOTE_B  = 4'(MID);
  localparam logic [3:0] RESOLVE = 4'(MID + 1);
  localparam logic [3:0] S_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(FRAME_DATA_BITS - 1);

  logic                       sync1_q, sync2_q;
  logic                       rx_s;
  logic                       tick;
  logic                       tick_clr;
  logic                       majority;

  rx_state_e                  state_q, state_d;
  logic [3:0]                 sample_q, sample_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [1:0]                 vote_q, vote_d;
  logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
  logic                       deliver_q, deliver_d;
  logic                       frame_err_q, frame_err_d;
  logic                       break_q, break_d;

  logic [7:0]                 rdata_q, rdata_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;

  // Two-flop synchronizer on the asynchronous serial line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
    end else begin
      sync1_q <= i_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Tick phase is held at zero in IDLE so sampling aligns to the start edge.
  assign tick_clr = (state_q == IDLE);

  uart_os_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // The third vote is the live sample taken on the resolve tick.
  assign majority = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

  // Receive FSM next state: sample counting, voting, shifting and frame checks.
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    bit_idx_d   = bit_idx_q;
    vote_d      = vote_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    break_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        sample_d  = '0;
        bit_idx_d = '0;
        if (rx_s == ~IDLE_LEVEL) begin
          state_d = START;
        end
      end

      START, DATA, STOP: begin
        if (tick) begin
          sample_d = (sample_q == S_LAST) ? 4'd0 : sample_q + 4'd1;
          if (sample_q == VOTE_A) begin
            vote_d[0] = rx_s;
          end
          if (sample_q == VOTE_B) begin
            vote_d[1] = rx_s;
          end
          if (sample_q == RESOLVE) begin
            if (state_q == START) begin
              if (majority) begin
                state_d = IDLE;
              end else begin
                state_d   = DATA;
                bit_idx_d = '0;
              end
            end else if (state_q == DATA) begin
              shift_d[bit_idx_q] = majority;
              if (bit_idx_q == BIT_LAST) begin
                state_d = STOP;
              end else begin
                bit_idx_d = bit_idx_q + 3'd1;
              end
            end else begin
              if (majority) begin
                deliver_d = 1'b1;
                state_d   = IDLE;
              end else if (shift_q != '0) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
              end else begin
                break_d  = 1'b1;
                state_d  = BRK_WAIT;
                sample_d = '0;
              end
            end
          end
        end
      end

      BRK_WAIT: begin
        if (tick) begin
          if (rx_s == IDLE_LEVEL) begin
            if (sample_q == S_LAST) begin
              state_d  = IDLE;
              sample_d = '0;
            end else begin
              sample_d = sample_q + 4'd1;
            end
          end else begin
            sample_d = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Receive FSM and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      bit_idx_q   <= '0;
      vote_q      <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      bit_idx_q   <= bit_idx_d;
      vote_q      <= vote_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      break_q     <= break_d;
    end
  end

  // Holding register: load on completion unless a full, unaccepted byte blocks it.
  always_comb begin
    rdata_d   = rdata_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (deliver_q) begin
      if (valid_q && !i_ready) begin
        overrun_d = 1'b1;
      end else begin
        rdata_d = shift_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register and overrun pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data      = rdata_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_break     = break_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16 at CLK_FREQ=1536000 / 9600 baud / x16, so one
// sample tick is 10 clocks and one bit is 160 clocks. Expected bytes are
// queued by the stimulus; a monitor pops and compares on every handshake
// and counts the high cycles of each status pulse.
module tb_uart_rx_os16;

  localparam int CLK_FREQ = 1536000;
  localparam int BAUD     = 9600;
  localparam int OS       = 16;
  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       rxLine = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] dataOut;
  logic       validOut;
  logic       frameErr;
  logic       brk;
  logic       overrun;
  logic       busy;

  int testsRun = 0;
  int testsFailed = 0;
  int validCycles = 0;
  int frameErrCycles = 0;
  int breakCycles = 0;
  int overrunCycles = 0;
  int snapValid, snapFe, snapBrk, snapOvr;

  logic [7:0] expQ[$];

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  uart_rx_os16 #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_in       (rxLine),
    .i_ready    (ready),
    .o_data     (dataOut),
    .o_valid    (validOut),
    .o_frame_err(frameErr),
    .o_break    (brk),
    .o_overrun  (overrun),
    .o_busy     (busy)
  );

  // One comparison: counted, and reported when it does not hold.
  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Hold the line at a level for a number of clocks, starting at a negedge.
  task automatic applyStimulus(input logic level, input int clocks);
    rxLine = level;
    repeat (clocks) @(negedge clk);
  endtask

  // Send one 8N1 frame; glitchBit >= 0 inverts that data bit briefly around its middle vote.
  task automatic sendFrame(input logic [7:0] b, input logic stopLevel, input int glitchBit);
    applyStimulus(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      if (i == glitchBit) begin
        applyStimulus(b[i], 88);
        applyStimulus(~b[i], 5);
        applyStimulus(b[i], 67);
      end else begin
        applyStimulus(b[i], BIT_CLKS);
      end
    end
    applyStimulus(stopLevel, BIT_CLKS);
  endtask

  task automatic snapshot();
    snapValid = validCycles;
    snapFe    = frameErrCycles;
    snapBrk   = breakCycles;
    snapOvr   = overrunCycles;
  endtask

  task automatic checkCounts(input string name, input int expValid, input int expFe,
                             input int expBrk, input int expOvr);
    checkOutput({name, " valid cycles"}, validCycles - snapValid, expValid);
    checkOutput({name, " frame_err cycles"}, frameErrCycles - snapFe, expFe);
    checkOutput({name, " break cycles"}, breakCycles - snapBrk, expBrk);
    checkOutput({name, " overrun cycles"}, overrunCycles - snapOvr, expOvr);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, " o_data"}, int'(dataOut), 0);
    checkOutput({name, " o_valid"}, int'(validOut), 0);
    checkOutput({name, " o_frame_err"}, int'(frameErr), 0);
    checkOutput({name, " o_break"}, int'(brk), 0);
    checkOutput({name, " o_overrun"}, int'(overrun), 0);
    checkOutput({name, " o_busy"}, int'(busy), 0);
  endtask

  // Monitor: pulse bookkeeping and scoreboard compare on each accepted byte.
  always @(negedge clk) begin
    if (validOut) validCycles++;
    if (frameErr) frameErrCycles++;
    if (brk) breakCycles++;
    if (overrun) overrunCycles++;
    if (validOut && ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected byte: got 0x%0h, expected no byte", dataOut);
      end else begin
        checkOutput("received byte", int'(dataOut), int'(expQ.pop_front()));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests run %0d", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    rstN   = 1'b0;
    ready  = 1'b1;
    rxLine = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rstN = 1'b1;
    applyStimulus(1'b1, 2 * BIT_CLKS);

    // Plain byte with downstream always ready.
    snapshot();
    expQ.push_back(8'h61);
    sendFrame(8'h61, 1'b1, -1);
    checkOutput("busy after 0x61 stop", int'(busy), 0);
    applyStimulus(1'b1, BIT_CLKS);
    checkCounts("0x61", 1, 0, 0, 0);

    // Short low glitch: false start, nothing reported.
    snapshot();
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 20);
    checkOutput("busy during false start", int'(busy), 1);
    applyStimulus(1'b1, 300);
    checkOutput("busy after false start", int'(busy), 0);
    checkCounts("glitch", 0, 0, 0, 0);

    // Inverted sample at the middle vote of data bit 3.
    snapshot();
    expQ.push_back(8'h55);
    sendFrame(8'h55, 1'b1, 3);
    applyStimulus(1'b1, BIT_CLKS);
    checkCounts("0x55 voted", 1, 0, 0, 0);

    // Stop bit low with non-zero data.
    snapshot();
    sendFrame(8'h55, 1'b0, -1);
    applyStimulus(1'b1, 3 * BIT_CLKS);
    checkOutput("busy after frame error", int'(busy), 0);
    checkCounts("frame error", 0, 1, 0, 0);

    // Long break, then a normal byte.
    snapshot();
    applyStimulus(1'b0, 20 * BIT_CLKS);
    applyStimulus(1'b1, 3 * BIT_CLKS);
    checkOutput("busy after break", int'(busy), 0);
    checkCounts("break", 0, 0, 1, 0);
    snapshot();
    expQ.push_back(8'h7A);
    sendFrame(8'h7A, 1'b1, -1);
    applyStimulus(1'b1, BIT_CLKS);
    checkCounts("0x7A after break", 1, 0, 0, 0);

    // Back-to-back bytes with downstream stalled.
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    snapshot();
    expQ.push_back(8'h41);
    sendFrame(8'h41, 1'b1, -1);
    sendFrame(8'h42, 1'b1, -1);
    applyStimulus(1'b1, BIT_CLKS);
    checkOutput("overrun cycles", overrunCycles - snapOvr, 1);
    checkOutput("retained o_data", int'(dataOut), 8'h41);
    checkOutput("retained o_valid", int'(validOut), 1);
    checkOutput("overrun frame_err", frameErrCycles - snapFe, 0);
    checkOutput("overrun break", breakCycles - snapBrk, 0);
    @(posedge clk);
    #1 ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("o_valid after accept", int'(validOut), 0);
    checkOutput("o_data after accept", int'(dataOut), 8'h41);

    // Reset in the middle of data bit 4 of 0x33, then 0x34.
    applyStimulus(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(((8'h33 >> i) & 8'h01) != 0, BIT_CLKS);
    end
    applyStimulus(1'b1, 80);
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("mid-frame reset");
    rxLine = 1'b1;
    rstN = 1'b1;
    applyStimulus(1'b1, 2 * BIT_CLKS);
    snapshot();
    expQ.push_back(8'h34);
    sendFrame(8'h34, 1'b1, -1);
    applyStimulus(1'b1, BIT_CLKS);
    checkCounts("0x34 after reset", 1, 0, 0, 0);

    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- Oversampling UART receive front end: 8N1 frames, LSB first, on the asynchronous serial input.
- Delivers bytes through a valid/ready holding register directly into the case-converter FIFO write path.
- Majority-vote sampling rejects glitches; flags framing errors, line breaks and overruns as single-cycle pulses for the status/debug logic.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- BAUD, 9600, line baud rate.
- OVERSAMPLE, 16, sample ticks per bit; legal range 8..16.
- DIV, (CLK_FREQ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE), clocks per sample tick (78 at defaults); derived, not overridden.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_in  in  1  raw serial RX line, asynchronous, idle high.
- i_ready  in  1  downstream accepts the byte this cycle when o_valid=1.
- o_data  out  8  received byte, stable while o_valid=1.
- o_valid  out  1  byte available; held until i_ready.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low, data non-zero.
- o_break  out  1  one-cycle pulse: data 0x00 and stop low.
- o_overrun  out  1  one-cycle pulse: byte completed while holding register still full.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, i_rst_n=0):
  - synchronizer flops = 1; FSM = IDLE; all counters = 0.
  - o_data=0x00; o_valid=0; o_frame_err=0; o_break=0; o_overrun=0; o_busy=0.
- Input conditioning:
  - 2-flop synchronizer on i_in; all logic uses the second flop (rx_s).
  - Edge/level latency from i_in is 2 clocks.
- Tick generator:
  - Counter 0..DIV-1; tick pulses one clock when the count wraps.
  - Counter is cleared in IDLE, so bit phase aligns to the detected start edge.
- Sample counter: 0..OVERSAMPLE-1 within each bit.
  - Votes are taken at samples M-1, M, M+1, where M = OVERSAMPLE/2.
  - Bit value = majority of the 3 votes, resolved on the M+1 tick.
- FSM:
  - IDLE: rx_s=0 -> START.
  - START: at resolve, majority=1 -> IDLE (false start, no flags); majority=0 -> DATA, bit index=0.
  - DATA: at each resolve, shift the majority bit into bit[index] (LSB first); after index 7 -> STOP.
  - STOP, at resolve, one of three cases:
    - majority=1 -> deliver byte, IDLE.
    - majority=0 and data!=0 -> o_frame_err pulse, byte discarded, IDLE.
    - majority=0 and data==0 -> o_break pulse, byte discarded, BRK_WAIT.
  - BRK_WAIT: stay until rx_s=1 for one full bit time (OVERSAMPLE consecutive high ticks), then IDLE. A long break produces exactly one o_break.
  - Return to IDLE happens mid-stop-bit, so the next start edge is caught with no dead time.
- Delivery:
  - The byte is loaded into the o_data register in the clock after the STOP resolve edge; o_valid rises that same cycle.
  - Byte accepted when o_valid && i_ready; o_valid falls next clock. o_data keeps its last value.
  - Completion while o_valid=1 and i_ready=0: the old byte is retained, the new byte is dropped, o_overrun pulses.
  - Completion in the same cycle as acceptance of the old byte: the new byte loads, o_valid stays 1, no overrun.
- Error pulses are mutually exclusive and independent of o_valid.
- Reset mid-frame: immediate return to reset values; a partial byte is never delivered.
- Widths:
  - Tick counter is $clog2(DIV) bits; sample counter 4 bits; bit index 3 bits.
  - DIV is computed in integer arithmetic; the residual rate error must be <2%, enforced by an elaboration check.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP, BRK_WAIT).
  - function calc_div(clk_freq, baud, os).
  - constants: FRAME_DATA_BITS=8, IDLE_LEVEL=1'b1.
- One sub-module, uart_os_tick: tick divider with synchronous clear input and tick output. The receive FSM, voter and holding register stay in uart_rx_os16.

Test Plan (bench may override CLK_FREQ=1536000 so DIV=10):
- Send 0x61 ('a') with i_ready=1 -> o_valid one cycle, o_data=0x61, no error pulses, o_busy low after mid-stop.
- Low glitch of 3 clocks on idle line -> FSM returns to IDLE from START; no o_valid, no flags.
- Single-sample inverted glitch at vote M of data bit 3 of 0x55 -> majority still yields o_data=0x55.
- Send 0x55 with stop bit forced low -> o_frame_err single pulse, o_valid stays 0.
- Hold line low for 20 bit times, then release -> exactly one o_break. Then 0x7A received correctly as 0x7A.
- Back-to-back 0x41 and 0x42 with i_ready=0 -> o_data=0x41 retained, one o_overrun pulse. Then i_ready=1 -> 0x41 accepted, o_valid drops.
- Reset asserted at data bit 4 of 0x33, released, then 0x34 sent -> all outputs 0 during reset. Then only 0x34 delivered.
